// File: rtl/rgb_pkg.sv
// Shared constants for the RGB fade controller: colour width, channel count
// and the register address map of the nine colour channels.
package rgb_pkg;

  localparam int unsigned COL_W  = 8;
  localparam int unsigned NUM_CH = 9;
  localparam int unsigned ADDR_W = 4;

  localparam int unsigned DEF_STEP_CYCLES = 195312;

  localparam logic [ADDR_W-1:0] ADDR_D1_ROT   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_D1_GRUEN = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_D1_BLAU  = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_D2_ROT   = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_D2_GRUEN = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_D2_BLAU  = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_D3_ROT   = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_D3_GRUEN = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_D3_BLAU  = 4'd8;

endpackage

// File: rtl/rgb_ramp_ch.sv
// One colour channel: holds its target and walks the displayed value toward
// it by one per tick, or copies it every cycle when fading is disabled.
module rgb_ramp_ch
  import rgb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             fade_en,
  input  logic             we,
  input  logic [COL_W-1:0] wdata,
  output logic [COL_W-1:0] cur,
  output logic             differ,
  output logic             changed
);

  logic [COL_W-1:0] tgt_q, tgt_d;
  logic [COL_W-1:0] cur_q, cur_d;

  // The ramp compares against tgt_q, so a write landing on a tick edge is
  // only seen by the following tick.
  always_comb begin
    tgt_d = tgt_q;
    if (we) begin
      tgt_d = wdata;
    end

    cur_d = cur_q;
    if (!fade_en) begin
      cur_d = tgt_q;
    end else if (tick) begin
      if (cur_q < tgt_q) begin
        cur_d = cur_q + 8'd1;
      end else if (cur_q > tgt_q) begin
        cur_d = cur_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= '0;
      cur_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
    end
  end

  assign cur     = cur_q;
  assign differ  = (cur_q != tgt_q);
  assign changed = (cur_d != cur_q);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Colour source for the PL9823 driver: nine register-written targets, each
// ramped or copied to a registered output, with step prescaler and status.
module rgb_fade_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned CNT_W       = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COL_W-1:0]  wr_data,
  input  logic              fade_en,
  output logic              wr_err,
  output logic              busy,
  output logic              update,
  output logic [COL_W-1:0]  D1_ROT,
  output logic [COL_W-1:0]  D1_GRUEN,
  output logic [COL_W-1:0]  D1_BLAU,
  output logic [COL_W-1:0]  D2_ROT,
  output logic [COL_W-1:0]  D2_GRUEN,
  output logic [COL_W-1:0]  D2_BLAU,
  output logic [COL_W-1:0]  D3_ROT,
  output logic [COL_W-1:0]  D3_GRUEN,
  output logic [COL_W-1:0]  D3_BLAU
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             wr_err_q, wr_err_d;
  logic             update_q, update_d;

  logic [NUM_CH-1:0] ch_we;
  logic [NUM_CH-1:0] ch_differ;
  logic [NUM_CH-1:0] ch_changed;
  logic [COL_W-1:0]  ch_cur [NUM_CH];

  assign tick = (cnt_q == CNT_W'(STEP_CYCLES - 1));

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    wr_err_d = wr_en && (wr_addr > ADDR_D3_BLAU);
    update_d = |ch_changed;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
      update_q <= update_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = wr_en && (wr_addr == ADDR_W'(i));

    rgb_ramp_ch u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .fade_en (fade_en),
      .we      (ch_we[i]),
      .wdata   (wr_data),
      .cur     (ch_cur[i]),
      .differ  (ch_differ[i]),
      .changed (ch_changed[i])
    );
  end

  assign wr_err = wr_err_q;
  assign update = update_q;
  assign busy   = |ch_differ;

  assign D1_ROT   = ch_cur[ADDR_D1_ROT];
  assign D1_GRUEN = ch_cur[ADDR_D1_GRUEN];
  assign D1_BLAU  = ch_cur[ADDR_D1_BLAU];
  assign D2_ROT   = ch_cur[ADDR_D2_ROT];
  assign D2_GRUEN = ch_cur[ADDR_D2_GRUEN];
  assign D2_BLAU  = ch_cur[ADDR_D2_BLAU];
  assign D3_ROT   = ch_cur[ADDR_D3_ROT];
  assign D3_GRUEN = ch_cur[ADDR_D3_GRUEN];
  assign D3_BLAU  = ch_cur[ADDR_D3_BLAU];

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
- Upstream colour source for the RGB_PL9823 serial LED driver.
- Holds target colours for 3 LEDs x {ROT, GRUEN, BLAU}, 8 bit each, written through a simple register write port.
- Ramps each displayed channel toward its target by ±1 per step tick, or jumps immediately when fading is disabled.
- Its nine colour outputs connect 1:1 to the driver's D1_ROT..D3_BLAU inputs.

Parameters:
- STEP_CYCLES, default 195312: clk cycles per ramp step. At 50 MHz, a full 0→255 fade takes about 1 s. Legal values are ≥2.
- CNT_W, default 18: prescaler width. Must satisfy 2^CNT_W ≥ STEP_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe, one cycle per write
- wr_addr  in  4  channel select; 0..8 = D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU, D3_ROT, D3_GRUEN, D3_BLAU
- wr_data  in  8  target value
- fade_en  in  1  1 = ramp outputs; 0 = outputs follow targets directly
- wr_err  out  1  one-cycle pulse on a write to an address in 9..15
- busy  out  1  high while any output differs from its target
- update  out  1  one-cycle pulse in the cycle after any colour output changed
- D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU, D3_ROT, D3_GRUEN, D3_BLAU  out  8 each  current displayed colour, registered

Behaviour:
- Reset (synchronous, active-high, takes effect on the clk edge where it is sampled high):
  - all targets = 0x00, all outputs = 0x00, prescaler = 0
  - wr_err = 0, update = 0, busy = 0
  - Reset mid-fade discards the fade in progress; no residual tick follows.
- Prescaler:
  - counts 0..STEP_CYCLES-1 and wraps to 0.
  - tick = 1 for the single cycle in which count == STEP_CYCLES-1.
  - Runs continuously and is independent of writes and fade_en.
- Write:
  - When wr_en=1 and wr_addr≤8, the target for that address takes wr_data at that edge.
  - When wr_en=1 and wr_addr≥9, no target changes and wr_err=1 in the following cycle only.
  - wr_en=0 means no write, whatever the address.
- Ramp (fade_en=1), on each tick, for each channel independently:
  - cur<tgt → cur+1
  - cur>tgt → cur−1
  - equal → hold
  - No wrap-around: values saturate naturally at the target; 0x00−1 and 0xFF+1 never occur.
- Write coinciding with tick on the same channel:
  - The tick compares against the old target.
  - The new target applies from the next tick.
  - The write is never lost.
- Direct mode (fade_en=0), every cycle: cur ← tgt.
  - A write with fade_en=0 appears on the output 2 edges after wr_en: target at edge 1, output at edge 2.
- fade_en 1→0 while busy: all outputs snap to their targets at the next edge.
- fade_en 0→1: the ramp resumes at the next tick; the prescaler phase is not reset.
- busy: combinational OR over all 9 channels of (cur≠tgt).
- update: registered; high for one cycle after any edge that changed any output value.
- Outputs change at most once per tick in fade mode, so the downstream driver may sample them at any time.

Decomposition:
- Shared package rgb_pkg:
  - COL_W=8, NUM_CH=9
  - address constants ADDR_D1_ROT=0 … ADDR_D3_BLAU=8
  - default STEP_CYCLES
- Sub-module rgb_ramp_ch, one channel, instantiated 9 times:
  - inputs: clk, reset, tick, fade_en, we, wdata
  - outputs: cur[7:0], differ, changed
- Top level holds the prescaler, address decode, wr_err, the busy OR and the update register.

Test Plan (STEP_CYCLES=4 on the bench):
1. Reset asserted for 3 cycles with wr_en=1 and random address/data → all 9 outputs 0x00, busy=0, update=0, wr_err=0; no target written.
2. fade_en=1, write addr0=0x03 → D1_ROT steps 0x01, 0x02, 0x03 on three consecutive ticks, 4 cycles apart. update pulses 3 times. busy falls in the cycle D1_ROT reaches 0x03.
3. fade_en=0, write addr5=0xFF → D2_BLAU=0xFF two edges after wr_en. One update pulse, busy high for exactly 1 cycle, other outputs unchanged.
4. fade_en=1, D3_GRUEN at 0x02, write target 0x00 → outputs 0x01, then 0x00, then stays 0x00 through 4 further ticks (no wrap to 0xFF). Repeat upward from 0xFE to target 0xFF → stays at 0xFF.
5. Write addr12=0x55 → wr_err high for exactly 1 cycle; all targets and outputs unchanged; busy unchanged.
6. Write addr1=0x10 on the same cycle as a tick with D1_GRUEN=tgt=0x00 → no change on that tick, 0x01 on the next tick. Then assert reset at D1_GRUEN=0x05 → all outputs 0x00 next edge and no further ticks change them.
